cpu_loader_mp: RTL and testbench

- Parametrised multi-slot program loader between the host CPU GPIO link and the GPU instruction memory.
- Receives a framed program stream on from_cpu using the same toggle-bit handshake as the current loader, and writes it into one of NUM_SLOTS fixed regions of instruction memory.
- Keeps a per-slot valid bitmap and announces each completed program to the scheduler.
- Adds abort, slot-overflow detection and a sticky error status to the CPU.

---
 rtl/cpu_loader_mp.sv | 186 ++++++++++++++++++
 tb/tb_cpu_loader_mp.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_loader_mp.sv
// cpu_loader_mp: multi-slot program loader from the CPU GPIO link into
// GPU instruction memory. Toggle-bit handshake on data words, per-slot
// valid bitmap, completion announcement, abort and sticky overflow error.

package opcode_pkg;
    localparam logic [2:0] X_TYPE  = 3'b111;
    localparam logic [2:0] C_TYPE  = 3'b110;
    localparam logic [1:0] X_START = 2'b00;
    localparam logic [1:0] X_END   = 2'b01;
    localparam logic [1:0] X_ABORT = 2'b11;
endpackage

module cpu_loader_mp
    import opcode_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 10,
    parameter int NUM_SLOTS  = 8,
    parameter int SLOT_DEPTH = 128,
    parameter int NB_W       = 18,
    parameter int TOGGLE_BIT = 4,
    parameter int FRAME_SLOT = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_W-1:0]    from_cpu,
    input  logic                 scheduler_busy,
    output logic [2:0]           to_cpu,
    output logic [ADDR_W-1:0]    instr_write_addr,
    output logic [DATA_W-1:0]    instr_write_data,
    output logic                 instr_write_en,
    output logic                 program_ready,
    output logic                 reset_frame,
    output logic                 prog_valid,
    output logic [2:0]           prog_slot,
    output logic [ADDR_W-1:0]    prog_start_addr,
    output logic [NB_W-1:0]      prog_num_blocks,
    output logic [ADDR_W-1:0]    prog_len,
    output logic [NUM_SLOTS-1:0] slot_valid
);

    typedef enum logic [1:0] {IDLE, LOAD_ODD, LOAD_EVEN, ERROR} state_t;

    localparam int              SLOT_SH      = $clog2(SLOT_DEPTH);
    localparam logic [ADDR_W:0] DEPTH_L      = (ADDR_W+1)'(SLOT_DEPTH);
    localparam logic [3:0]      NUM_SLOTS_L  = 4'(NUM_SLOTS);
    localparam logic [2:0]      FRAME_SLOT_L = 3'(FRAME_SLOT);

    state_t                 state, state_d;
    logic [2:0]             cur_slot, cur_slot_d;
    logic [ADDR_W:0]        offset, offset_d;     // one extra bit so it can reach SLOT_DEPTH
    logic [NB_W-1:0]        num_blocks, num_blocks_d;

    logic [2:0]             to_cpu_d;
    logic [ADDR_W-1:0]      waddr_d;
    logic [DATA_W-1:0]      wdata_d;
    logic                   we_d, ready_d, frame_d, pvalid_d;
    logic [2:0]             pslot_d;
    logic [ADDR_W-1:0]      pstart_d, plen_d;
    logic [NB_W-1:0]        pnb_d;
    logic [NUM_SLOTS-1:0]   slot_valid_d;

    logic [2:0]             opc, in_slot;
    logic [1:0]             func2;
    logic                   is_x, is_c, is_data, in_load, do_write;
    logic [ADDR_W-1:0]      base_addr;
    logic [ADDR_W:0]        offset_inc;

    // Decode the incoming word and compute next state plus next value of every registered output.
    always_comb begin
        // NOTE: every always_comb target gets a default first so no path can infer a latch.
        state_d      = state;
        cur_slot_d   = cur_slot;
        offset_d     = offset;
        num_blocks_d = num_blocks;
        waddr_d      = instr_write_addr;
        wdata_d      = instr_write_data;
        we_d         = 1'b0;
        ready_d      = 1'b0;
        frame_d      = 1'b0;
        pvalid_d     = 1'b0;
        pslot_d      = prog_slot;
        pstart_d     = prog_start_addr;
        pnb_d        = prog_num_blocks;
        plen_d       = prog_len;
        slot_valid_d = slot_valid;

        opc        = from_cpu[31:29];
        func2      = from_cpu[28:27];
        in_slot    = from_cpu[26:24];
        is_x       = (opc == X_TYPE);
        is_c       = (opc == C_TYPE);
        is_data    = !is_x && !is_c;
        in_load    = (state == LOAD_ODD) || (state == LOAD_EVEN);
        // LOAD_ODD waits for toggle=1, LOAD_EVEN for toggle=0; the C word ignores the toggle.
        do_write   = in_load && (is_c || (is_data && (from_cpu[TOGGLE_BIT] == (state == LOAD_ODD))));
        base_addr  = ADDR_W'(cur_slot) << SLOT_SH;
        offset_inc = offset + (ADDR_W+1)'(1);

        if (is_x && func2 == X_START) begin
            // Start is honoured from every state; a start mid-load discards the partial program.
            if ({1'b0, in_slot} < NUM_SLOTS_L) begin
                state_d      = LOAD_ODD;
                cur_slot_d   = in_slot;
                num_blocks_d = from_cpu[NB_W-1:0];
                offset_d     = '0;
                slot_valid_d = slot_valid & ~(NUM_SLOTS'(1) << in_slot);
                ready_d      = 1'b1;
                frame_d      = (in_slot == FRAME_SLOT_L);
            end else begin
                state_d = ERROR;
            end
        end else if (is_x && func2 == X_ABORT) begin
            state_d = IDLE;
        end else if (do_write) begin
            if (offset == DEPTH_L) begin
                state_d = ERROR;
            end else begin
                we_d     = 1'b1;
                waddr_d  = base_addr + offset[ADDR_W-1:0];
                wdata_d  = from_cpu;
                offset_d = offset_inc;
                if (is_c) begin
                    state_d      = IDLE;
                    slot_valid_d = slot_valid | (NUM_SLOTS'(1) << cur_slot);
                    pvalid_d     = 1'b1;
                    pslot_d      = cur_slot;
                    pstart_d     = base_addr;
                    pnb_d        = num_blocks;
                    plen_d       = offset_inc[ADDR_W-1:0];
                end else begin
                    state_d = (state == LOAD_ODD) ? LOAD_EVEN : LOAD_ODD;
                end
            end
        end

        case (state_d)
            IDLE:      to_cpu_d = {2'b00, scheduler_busy};
            LOAD_ODD:  to_cpu_d = 3'b011;
            LOAD_EVEN: to_cpu_d = 3'b010;
            ERROR:     to_cpu_d = 3'b100;
            default:   to_cpu_d = 3'b000;
        endcase
    end

    // State and registered outputs, cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            state            <= IDLE;
            cur_slot         <= '0;
            offset           <= '0;
            num_blocks       <= '0;
            to_cpu           <= '0;
            instr_write_addr <= '0;
            instr_write_data <= '0;
            instr_write_en   <= 1'b0;
            program_ready    <= 1'b0;
            reset_frame      <= 1'b0;
            prog_valid       <= 1'b0;
            prog_slot        <= '0;
            prog_start_addr  <= '0;
            prog_num_blocks  <= '0;
            prog_len         <= '0;
            slot_valid       <= '0;
        end else begin
            state            <= state_d;
            cur_slot         <= cur_slot_d;
            offset           <= offset_d;
            num_blocks       <= num_blocks_d;
            to_cpu           <= to_cpu_d;
            instr_write_addr <= waddr_d;
            instr_write_data <= wdata_d;
            instr_write_en   <= we_d;
            program_ready    <= ready_d;
            reset_frame      <= frame_d;
            prog_valid       <= pvalid_d;
            prog_slot        <= pslot_d;
            prog_start_addr  <= pstart_d;
            prog_num_blocks  <= pnb_d;
            prog_len         <= plen_d;
            slot_valid       <= slot_valid_d;
        end
    end

endmodule

// File: tb/tb_cpu_loader_mp.sv
// Testbench for cpu_loader_mp: directed scenarios plus randomized program
// loads checked against a transaction-level model of expected writes,
// completions and the slot-valid bitmap.

module tb_cpu_loader_mp;
    import opcode_pkg::*;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 10;
    localparam int NUM_SLOTS  = 8;
    localparam int SLOT_DEPTH = 128;
    localparam int NB_W       = 18;
    localparam int TB         = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [DATA_W-1:0]    from_cpu;
    logic                 scheduler_busy;
    logic [2:0]           to_cpu;
    logic [ADDR_W-1:0]    instr_write_addr;
    logic [DATA_W-1:0]    instr_write_data;
    logic                 instr_write_en;
    logic                 program_ready;
    logic                 reset_frame;
    logic                 prog_valid;
    logic [2:0]           prog_slot;
    logic [ADDR_W-1:0]    prog_start_addr;
    logic [NB_W-1:0]      prog_num_blocks;
    logic [ADDR_W-1:0]    prog_len;
    logic [NUM_SLOTS-1:0] slot_valid;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    typedef struct {
        logic [2:0]        slot;
        logic [ADDR_W-1:0] start;
        logic [NB_W-1:0]   nb;
        logic [ADDR_W-1:0] len;
    } pv_t;

    wr_t wq[$];
    pv_t pq[$];
    logic [NUM_SLOTS-1:0] sv_m;

    cpu_loader_mp #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_SLOTS(NUM_SLOTS),
        .SLOT_DEPTH(SLOT_DEPTH), .NB_W(NB_W), .TOGGLE_BIT(TB), .FRAME_SLOT(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .from_cpu(from_cpu), .scheduler_busy(scheduler_busy),
        .to_cpu(to_cpu), .instr_write_addr(instr_write_addr),
        .instr_write_data(instr_write_data), .instr_write_en(instr_write_en),
        .program_ready(program_ready), .reset_frame(reset_frame),
        .prog_valid(prog_valid), .prog_slot(prog_slot),
        .prog_start_addr(prog_start_addr), .prog_num_blocks(prog_num_blocks),
        .prog_len(prog_len), .slot_valid(slot_valid)
    );

    always #5 clk = ~clk;

    // Record every write strobe and completion pulse on the falling edge.
    always @(negedge clk) begin
        if (instr_write_en) wq.push_back('{instr_write_addr, instr_write_data});
        if (prog_valid)     pq.push_back('{prog_slot, prog_start_addr, prog_num_blocks, prog_len});
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [DATA_W-1:0] mk_x(input logic [1:0] f2, input logic [2:0] s,
                                               input logic [NB_W-1:0] nb);
        return {X_TYPE, f2, s, 6'b0, nb};
    endfunction

    function automatic logic [DATA_W-1:0] mk_c();
        logic [28:0] p;
        p = 29'($urandom);
        return {C_TYPE, p};
    endfunction

    function automatic logic [DATA_W-1:0] mk_data(input logic tog);
        logic [DATA_W-1:0] w;
        w       = $urandom;
        w[31:29] = 3'($urandom_range(0, 5));
        w[TB]   = tog;
        return w;
    endfunction

    function automatic logic [DATA_W-1:0] neutral();
        return mk_x(X_END, 3'd0, '0);
    endfunction

    task automatic send(input logic [DATA_W-1:0] w);
        from_cpu = w;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        scheduler_busy = 1'b1;
        from_cpu = mk_data(1'b1);
        wait_cycles(2);
        n_checks++;
        if ({to_cpu, instr_write_en, program_ready, reset_frame, prog_valid} !== 7'd0) begin
            n_fail++; $display("FAIL reset_ctrl: got %0h expected 0",
                               {to_cpu, instr_write_en, program_ready, reset_frame, prog_valid});
        end
        n_checks++;
        if ({slot_valid, prog_slot, prog_start_addr, prog_num_blocks, prog_len} !== '0) begin
            n_fail++; $display("FAIL reset_prog: slot_valid %0h len %0h nb %0h", slot_valid, prog_len, prog_num_blocks);
        end
        n_checks++;
        if ({instr_write_addr, instr_write_data} !== '0) begin
            n_fail++; $display("FAIL reset_wr: addr %0h data %0h expected 0", instr_write_addr, instr_write_data);
        end
        rst_n = 1'b1;
        from_cpu = neutral();
        wait_cycles(1);
        n_checks++;
        if (to_cpu !== 3'b001) begin n_fail++; $display("FAIL idle_busy: got %b expected 001", to_cpu); end
        scheduler_busy = 1'b0;
        wait_cycles(1);
        n_checks++;
        if (to_cpu !== 3'b000) begin n_fail++; $display("FAIL idle_free: got %b expected 000", to_cpu); end
        sv_m = '0;
    endtask

    task automatic test_basic_load();
        logic [DATA_W-1:0] words[4];
        wq.delete(); pq.delete();
        send(mk_x(X_START, 3'd2, 18'd5));
        n_checks++;
        if ({program_ready, reset_frame, to_cpu} !== 5'b10_011) begin
            n_fail++; $display("FAIL start_s2: ready %b frame %b to_cpu %b expected 1 0 011", program_ready, reset_frame, to_cpu);
        end
        words[0] = mk_data(1'b1); send(words[0]);
        n_checks++;
        if (to_cpu !== 3'b010) begin n_fail++; $display("FAIL to_even: got %b expected 010", to_cpu); end
        words[1] = mk_data(1'b0); send(words[1]);
        words[2] = mk_data(1'b1); send(words[2]);
        words[3] = mk_c();        send(words[3]);
        n_checks++;
        if ({prog_valid, prog_slot, prog_start_addr, prog_num_blocks, prog_len} !==
            {1'b1, 3'd2, 10'h100, 18'd5, 10'd4}) begin
            n_fail++; $display("FAIL prog_s2: valid %b slot %0d start %0h nb %0d len %0d expected 1 2 100 5 4",
                               prog_valid, prog_slot, prog_start_addr, prog_num_blocks, prog_len);
        end
        n_checks++;
        if (slot_valid !== 8'b0000_0100) begin n_fail++; $display("FAIL sv_s2: got %b expected 00000100", slot_valid); end
        from_cpu = neutral();
        wait_cycles(1);
        n_checks++;
        if ({prog_valid, program_ready, to_cpu} !== 5'b00_000) begin
            n_fail++; $display("FAIL pulses_end: prog_valid %b ready %b to_cpu %b", prog_valid, program_ready, to_cpu);
        end
        n_checks++;
        if (wq.size() != 4) begin
            n_fail++; $display("FAIL wr_count_s2: got %0d expected 4", wq.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (wq[i].a !== 10'h100 + 10'(i) || wq[i].d !== words[i]) begin
                    n_fail++; $display("FAIL wr_s2_%0d: got %0h/%0h expected %0h/%0h",
                                       i, wq[i].a, wq[i].d, 10'h100 + 10'(i), words[i]);
                end
            end
        end
        sv_m[2] = 1'b1;
    endtask

    task automatic test_hold();
        wq.delete(); pq.delete();
        send(mk_x(X_START, 3'd4, 18'h3ffff));
        from_cpu = mk_data(1'b1);
        wait_cycles(10);
        n_checks++;
        if (to_cpu !== 3'b010) begin n_fail++; $display("FAIL hold_state: got %b expected 010", to_cpu); end
        n_checks++;
        if (wq.size() != 1) begin n_fail++; $display("FAIL hold_writes: got %0d expected 1", wq.size()); end
        send(mk_c());
        from_cpu = neutral();
        wait_cycles(1);
        n_checks++;
        if (pq.size() != 1 || pq[0].len !== 10'd2 || pq[0].nb !== 18'h3ffff || pq[0].start !== 10'h200) begin
            n_fail++; $display("FAIL hold_prog: count %0d expected 1 with len 2 nb 3ffff start 200", pq.size());
        end
        sv_m[4] = 1'b1;
        n_checks++;
        if (slot_valid !== sv_m) begin n_fail++; $display("FAIL hold_sv: got %b expected %b", slot_valid, sv_m); end
    endtask

    task automatic test_frame();
        send(mk_x(X_START, 3'd0, 18'd1));
        n_checks++;
        if ({reset_frame, program_ready} !== 2'b11) begin
            n_fail++; $display("FAIL frame_s0: frame %b ready %b expected 1 1", reset_frame, program_ready);
        end
        send(neutral());
        n_checks++;
        if ({reset_frame, program_ready} !== 2'b00) begin
            n_fail++; $display("FAIL frame_pulse: frame %b ready %b expected 0 0", reset_frame, program_ready);
        end
        send(mk_x(X_ABORT, 3'd0, '0));
        send(mk_x(X_START, 3'd1, 18'd1));
        n_checks++;
        if ({reset_frame, program_ready} !== 2'b01) begin
            n_fail++; $display("FAIL frame_s1: frame %b ready %b expected 0 1", reset_frame, program_ready);
        end
        send(mk_x(X_ABORT, 3'd0, '0));
        sv_m[0] = 1'b0; sv_m[1] = 1'b0;
    endtask

    task automatic test_overflow();
        logic ok;
        wq.delete(); pq.delete();
        send(mk_x(X_START, 3'd1, 18'd9));
        for (int i = 0; i < SLOT_DEPTH; i++) send(mk_data(i % 2 == 0));
        send(mk_data(1'b1));
        n_checks++;
        if ({instr_write_en, to_cpu} !== 4'b0_100) begin
            n_fail++; $display("FAIL ovf_enter: we %b to_cpu %b expected 0 100", instr_write_en, to_cpu);
        end
        scheduler_busy = 1'b1;
        send(mk_c());
        send(mk_data(1'b0));
        n_checks++;
        if (to_cpu !== 3'b100) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 100", to_cpu); end
        send(mk_x(X_ABORT, 3'd0, '0));
        n_checks++;
        if (to_cpu !== 3'b001) begin n_fail++; $display("FAIL ovf_abort: got %b expected 001", to_cpu); end
        scheduler_busy = 1'b0;
        send(neutral());
        ok = (wq.size() == SLOT_DEPTH);
        for (int i = 0; i < wq.size() && ok; i++) ok = (wq[i].a == 10'h080 + 10'(i));
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL ovf_writes: got %0d writes expected %0d at 080..0ff", wq.size(), SLOT_DEPTH); end
        n_checks++;
        if (pq.size() != 0 || slot_valid !== sv_m) begin
            n_fail++; $display("FAIL ovf_sv: prog %0d sv %b expected 0 %b", pq.size(), slot_valid, sv_m);
        end
    endtask

    task automatic test_abort_reload();
        send(mk_x(X_START, 3'd3, 18'd2));
        send(mk_data(1'b1));
        send(mk_c());
        sv_m[3] = 1'b1;
        n_checks++;
        if (slot_valid !== sv_m) begin n_fail++; $display("FAIL ar_loaded: got %b expected %b", slot_valid, sv_m); end
        send(neutral());
        pq.delete();
        send(mk_x(X_START, 3'd3, 18'd2));
        sv_m[3] = 1'b0;
        n_checks++;
        if (slot_valid !== sv_m) begin n_fail++; $display("FAIL ar_cleared: got %b expected %b", slot_valid, sv_m); end
        send(mk_data(1'b1));
        send(mk_data(1'b0));
        send(mk_x(X_ABORT, 3'd0, '0));
        send(mk_c());
        wait_cycles(2);
        n_checks++;
        if (slot_valid !== sv_m || pq.size() != 0) begin
            n_fail++; $display("FAIL ar_after: sv %b prog %0d expected %b 0", slot_valid, pq.size(), sv_m);
        end
    endtask

    task automatic test_reset_mid_load();
        scheduler_busy = 1'b1;
        send(mk_x(X_START, 3'd5, 18'd7));
        send(mk_data(1'b1));
        send(mk_data(1'b0));
        rst_n = 1'b0;
        wait_cycles(1);
        n_checks++;
        if ({to_cpu, instr_write_en, program_ready, reset_frame, prog_valid, slot_valid, prog_len} !== '0) begin
            n_fail++; $display("FAIL mid_reset: to_cpu %b we %b sv %b len %0d expected all 0",
                               to_cpu, instr_write_en, slot_valid, prog_len);
        end
        rst_n = 1'b1;
        sv_m = '0;
        wq.delete();
        send(mk_data(1'b1));
        send(mk_data(1'b0));
        n_checks++;
        if (to_cpu !== 3'b001 || wq.size() != 0) begin
            n_fail++; $display("FAIL post_reset: to_cpu %b writes %0d expected 001 0", to_cpu, wq.size());
        end
        scheduler_busy = 1'b0;
    endtask

    task automatic test_random();
        wr_t ew[$];
        logic [2:0] s;
        logic [NB_W-1:0] nb;
        logic [ADDR_W-1:0] base;
        logic [DATA_W-1:0] w;
        logic tog, ok;
        int n, ending, exp_pv;
        for (int it = 0; it < 40; it++) begin
            wq.delete(); pq.delete(); ew.delete();
            scheduler_busy = 1'($urandom);
            s    = 3'($urandom);
            nb   = NB_W'($urandom);
            base = ADDR_W'(s) * ADDR_W'(SLOT_DEPTH);
            send(mk_x(X_START, s, nb));
            sv_m[s] = 1'b0;
            n   = $urandom_range(0, 7);
            tog = 1'b1;
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) send(mk_data(!tog));
                if ($urandom_range(0, 4) == 0) send(mk_x(X_END, 3'($urandom), '0));
                w = mk_data(tog);
                from_cpu = w;
                wait_cycles($urandom_range(1, 3));
                ew.push_back('{base + ADDR_W'(i), w});
                tog = !tog;
            end
            ending = $urandom_range(0, 2);
            exp_pv = 0;
            if (ending == 0) begin
                w = mk_c();
                from_cpu = w;
                wait_cycles($urandom_range(1, 2));
                ew.push_back('{base + ADDR_W'(n), w});
                exp_pv  = 1;
                sv_m[s] = 1'b1;
            end else if (ending == 1) begin
                send(mk_x(X_ABORT, 3'd0, '0));
            end
            send(neutral());
            ok = (wq.size() == ew.size());
            for (int i = 0; i < wq.size() && ok; i++) ok = (wq[i].a === ew[i].a) && (wq[i].d === ew[i].d);
            n_checks++;
            if (!ok) begin n_fail++; $display("FAIL rnd_writes[%0d]: got %0d writes expected %0d", it, wq.size(), ew.size()); end
            n_checks++;
            if (pq.size() != exp_pv) begin
                n_fail++; $display("FAIL rnd_pv_count[%0d]: got %0d expected %0d", it, pq.size(), exp_pv);
            end else if (exp_pv == 1) begin
                n_checks++;
                if (pq[0].slot !== s || pq[0].start !== base || pq[0].nb !== nb || pq[0].len !== ADDR_W'(n + 1)) begin
                    n_fail++; $display("FAIL rnd_pv[%0d]: slot %0d start %0h nb %0h len %0d expected %0d %0h %0h %0d",
                                       it, pq[0].slot, pq[0].start, pq[0].nb, pq[0].len, s, base, nb, n + 1);
                end
            end
            n_checks++;
            if (slot_valid !== sv_m) begin n_fail++; $display("FAIL rnd_sv[%0d]: got %b expected %b", it, slot_valid, sv_m); end
            if (ending != 2) begin
                n_checks++;
                if (to_cpu !== {2'b00, scheduler_busy}) begin
                    n_fail++; $display("FAIL rnd_idle[%0d]: got %b expected %b", it, to_cpu, {2'b00, scheduler_busy});
                end
            end
        end
        send(mk_x(X_ABORT, 3'd0, '0));
    endtask

    initial begin
        rst_n = 1'b0;
        scheduler_busy = 1'b0;
        from_cpu = '0;
        sv_m = '0;
        test_reset();
        test_basic_load();
        test_hold();
        test_frame();
        test_overflow();
        test_abort_reload();
        test_reset_mid_load();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
